drive_ramp: RTL and testbench

//  Slew-rate limiter and saturator sitting directly upstream of the motor PWM

---
 rtl/drv_pkg.sv | 24 ++
 rtl/drv_ramp_axis.sv | 50 +++++
 rtl/drive_ramp.sv | 148 ++++++++++++++
 tb/tb_drive_ramp.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drv_pkg.sv
// Shared types for the drive ramp: command word, wheel pair, FSM state, clamp.
package drv_pkg;

  localparam int MAX_MAG = 1023;

  typedef logic signed [10:0] cmd_t;

  typedef struct packed {
    cmd_t lft;
    cmd_t rht;
  } wheel_pair_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    BRAKE = 2'd2
  } state_t;

  // -1024 has no positive twin, so the PWM magnitude path must never see it.
  function automatic cmd_t clamp11(input cmd_t v);
    return (v == cmd_t'(-MAX_MAG - 1)) ? cmd_t'(-MAX_MAG) : v;
  endfunction

endpackage

// File: rtl/drv_ramp_axis.sv
// One wheel's next ramp value: moves cur toward tgt by at most one step.
// Purely combinational; the caller decides when to apply the result.
module drv_ramp_axis
  import drv_pkg::*;
(
  input  logic signed [10:0] cur,
  input  logic signed [10:0] tgt,
  input  logic [10:0]        step,
  input  logic [10:0]        decel_step,
  input  logic               decel_en,
  output logic signed [10:0] nxt
);

  logic signed [11:0] cur_w;
  logic signed [11:0] tgt_w;
  logic signed [11:0] aim_w;
  logic signed [11:0] diff_w;
  logic signed [11:0] res_w;
  logic [11:0]        cur_abs;
  logic [11:0]        tgt_abs;
  logic [11:0]        mag_w;
  logic [11:0]        stp_w;
  logic               opposite;
  logic               decel;

  always_comb begin
    cur_w    = {cur[10], cur};
    tgt_w    = {tgt[10], tgt};
    cur_abs  = cur[10] ? unsigned'(-cur_w) : unsigned'(cur_w);
    tgt_abs  = tgt[10] ? unsigned'(-tgt_w) : unsigned'(tgt_w);
    opposite = (cur != '0) && (tgt != '0) && (cur[10] != tgt[10]);
    decel    = decel_en && (cur != '0) && (opposite || (tgt_abs < cur_abs));

    // A decelerating move toward the other sign parks at zero for one tick.
    aim_w  = (decel && opposite) ? 12'sd0 : tgt_w;
    stp_w  = decel ? {1'b0, decel_step} : {1'b0, step};
    diff_w = aim_w - cur_w;
    mag_w  = diff_w[11] ? unsigned'(-diff_w) : unsigned'(diff_w);

    if (mag_w <= stp_w) begin
      res_w = aim_w;
    end else if (diff_w[11]) begin
      res_w = cur_w - signed'(stp_w);
    end else begin
      res_w = cur_w + signed'(stp_w);
    end
    nxt = cmd_t'(res_w);
  end

endmodule

// File: rtl/drive_ramp.sv
// Slew limiter/saturator for left/right wheel commands ahead of PWM; DRV_RAMP_DECEL_EN adds fast decel.
// Outputs move on the first tick >=1 cycle after a transfer; tgt_rdy drops while braking.
module drive_ramp
  import drv_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int STEP       = 8,
  parameter int BRAKE_STEP = 64,
  parameter int DECEL_STEP = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [10:0] tgt_lft,
  input  logic signed [10:0] tgt_rht,
  input  logic               tgt_vld,
  output logic               tgt_rdy,
  input  logic               brake,
  output logic signed [10:0] lft,
  output logic signed [10:0] rht,
  output logic               settled,
  output logic               ramping
);

  localparam int               CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [10:0]      STEP_V   = 11'(STEP);
  localparam logic [10:0]      BRAKE_V  = 11'(BRAKE_STEP);
  localparam logic [10:0]      DECEL_V  = 11'(DECEL_STEP);
`ifdef DRV_RAMP_DECEL_EN
  localparam logic             DECEL_ON = 1'b1;
`else
  localparam logic             DECEL_ON = 1'b0;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  state_t           state_q, state_d;
  wheel_pair_t      tgt_q, tgt_d, tgt_in;
  cmd_t             lft_q, lft_d, rht_q, rht_d;
  cmd_t             axis_tgt_lft, axis_tgt_rht;
  cmd_t             nxt_lft, nxt_rht;
  logic [10:0]      axis_step;
  logic             axis_decel;
  logic             braking;
  logic             xfer;

  // Free-running tick; nothing else restarts it.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    braking      = (state_q == BRAKE);
    xfer         = tgt_vld & tgt_rdy;
    tgt_in.lft   = clamp11(tgt_lft);
    tgt_in.rht   = clamp11(tgt_rht);
    axis_tgt_lft = braking ? '0 : tgt_q.lft;
    axis_tgt_rht = braking ? '0 : tgt_q.rht;
    axis_step    = braking ? BRAKE_V : STEP_V;
    axis_decel   = DECEL_ON & ~braking;
    lft_d        = tick ? nxt_lft : lft_q;
    rht_d        = tick ? nxt_rht : rht_q;

    // The step above uses tgt_q, so a transfer on a tick cycle lands after it.
    tgt_d = tgt_q;
    if (braking) begin
      tgt_d = '0;
    end else if (xfer) begin
      tgt_d = tgt_in;
    end
  end

  drv_ramp_axis u_axis_lft (
    .cur        (lft_q),
    .tgt        (axis_tgt_lft),
    .step       (axis_step),
    .decel_step (DECEL_V),
    .decel_en   (axis_decel),
    .nxt        (nxt_lft)
  );

  drv_ramp_axis u_axis_rht (
    .cur        (rht_q),
    .tgt        (axis_tgt_rht),
    .step       (axis_step),
    .decel_step (DECEL_V),
    .decel_en   (axis_decel),
    .nxt        (nxt_rht)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (brake) begin
          state_d = BRAKE;
        end else if (xfer && ((tgt_in.lft != lft_q) || (tgt_in.rht != rht_q))) begin
          state_d = RAMP;
        end
      end
      RAMP: begin
        if (brake) begin
          state_d = BRAKE;
        end else if (tick && !xfer && (lft_d == tgt_q.lft) && (rht_d == tgt_q.rht)) begin
          state_d = IDLE;
        end
      end
      BRAKE: begin
        if (!brake) begin
          state_d = ((lft_d == '0) && (rht_d == '0)) ? IDLE : RAMP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tgt_rdy = (state_q != BRAKE) & ~brake;
    settled = (state_q == IDLE);
    ramping = (state_q == RAMP) | (state_q == BRAKE);
    lft     = lft_q;
    rht     = rht_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tgt_q <= '0;
      lft_q <= '0;
      rht_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      lft_q <= lft_d;
      rht_q <= rht_d;
    end
  end

endmodule

// File: tb/tb_drive_ramp.sv
// Scoreboarded bench for drive_ramp: directed scenarios followed by randomized targets and brake pulses.
module tb_drive_ramp;

  localparam int TICK_DIV   = 4;
  localparam int STEP       = 8;
  localparam int BRAKE_STEP = 64;
  localparam int DECEL_STEP = 32;
`ifdef DRV_RAMP_DECEL_EN
  localparam bit DECEL_ON = 1'b1;
`else
  localparam bit DECEL_ON = 1'b0;
`endif

  logic               clk     = 1'b0;
  logic               rst_n   = 1'b0;
  logic signed [10:0] tgt_lft = '0;
  logic signed [10:0] tgt_rht = '0;
  logic               tgt_vld = 1'b0;
  logic               brake   = 1'b0;
  logic               tgt_rdy;
  logic signed [10:0] lft;
  logic signed [10:0] rht;
  logic               settled;
  logic               ramping;

  always #5 clk = ~clk;

  drive_ramp #(
    .TICK_DIV   (TICK_DIV),
    .STEP       (STEP),
    .BRAKE_STEP (BRAKE_STEP),
    .DECEL_STEP (DECEL_STEP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tgt_lft (tgt_lft),
    .tgt_rht (tgt_rht),
    .tgt_vld (tgt_vld),
    .tgt_rdy (tgt_rdy),
    .brake   (brake),
    .lft     (lft),
    .rht     (rht),
    .settled (settled),
    .ramping (ramping)
  );

  typedef struct {
    int c;
    int l;
    int r;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  // Reference: wheel positions, held targets, tick phase, and "brake seen last edge".
  int m_l = 0, m_r = 0, m_tl = 0, m_tr = 0, m_cnt = 0;
  bit m_brk = 1'b0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(input int v);
    return (v < -1023) ? -1023 : v;
  endfunction

  function automatic int move(input int cur, input int tgt, input int s, input bit may_decel);
    int aim;
    int st;
    aim = tgt;
    st  = s;
    if (DECEL_ON && may_decel && cur != 0 && (cur * tgt < 0 || iabs(tgt) < iabs(cur))) begin
      st = DECEL_STEP;
      if (cur * tgt < 0) aim = 0;
    end
    if (iabs(aim - cur) <= st) return aim;
    return (aim > cur) ? cur + st : cur - st;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int nl, nr;
    bit tick, xfer;
    if (!rst_n) begin
      m_l = 0; m_r = 0; m_tl = 0; m_tr = 0; m_cnt = 0; m_brk = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      tick  = (m_cnt == TICK_DIV - 1);
      m_cnt = (m_cnt + 1) % TICK_DIV;
      xfer  = tgt_vld && !m_brk && !brake;
      nl = m_l;
      nr = m_r;
      if (tick) begin
        if (m_brk) begin
          nl = move(m_l, 0, BRAKE_STEP, 1'b0);
          nr = move(m_r, 0, BRAKE_STEP, 1'b0);
        end else begin
          nl = move(m_l, m_tl, STEP, 1'b1);
          nr = move(m_r, m_tr, STEP, 1'b1);
        end
      end
      if (nl != m_l || nr != m_r) exp_q.push_back('{cyc, nl, nr});
      m_l = nl;
      m_r = nr;
      if (m_brk) begin
        m_tl = 0;
        m_tr = 0;
      end else if (xfer) begin
        m_tl = clampi(int'(tgt_lft));
        m_tr = clampi(int'(tgt_rht));
      end
      m_brk = brake;
    end
  end

  int prev_l = 0, prev_r = 0;

  always @(negedge clk or negedge rst_n) begin
    ev_t e;
    if (!rst_n) begin
      prev_l = 0;
      prev_r = 0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        chk("missed_change_cycle", cyc, exp_q[0].c);
        void'(exp_q.pop_front());
      end
      if (int'(lft) != prev_l || int'(rht) != prev_r) begin
        if (exp_q.size() == 0) begin
          chk("change_was_expected", int'(exp_q.size() > 0), 1);
        end else begin
          e = exp_q.pop_front();
          chk("out_cycle", cyc, e.c);
          chk("out_lft", int'(lft), e.l);
          chk("out_rht", int'(rht), e.r);
        end
        chk("lft_min_code", int'(int'(lft) == -1024), 0);
        prev_l = int'(lft);
        prev_r = int'(rht);
      end
    end
  end

  task automatic send(input int l, input int r);
    chk("send_rdy", int'(tgt_rdy), 1);
    tgt_lft = 11'(l);
    tgt_rht = 11'(r);
    tgt_vld = 1'b1;
    @(negedge clk);
    tgt_vld = 1'b0;
  endtask

  task automatic wait_settled(input string name, input int el, input int er);
    int n;
    n = 0;
    while (!(settled && exp_q.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_settle_timeout"}, int'(n < 3000), 1);
    chk({name, "_lft"}, int'(lft), el);
    chk({name, "_rht"}, int'(rht), er);
    chk({name, "_ramping"}, int'(ramping), 0);
  endtask

  task automatic wait_lft(input string name, input int v);
    int n;
    n = 0;
    while (int'(lft) != v && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reach_timeout"}, int'(n < 3000), 1);
  endtask

  task automatic wait_change(input string name);
    int n;
    int p;
    n = 0;
    p = int'(lft);
    while (int'(lft) == p && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_change_timeout"}, int'(n < 100), 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_lft", int'(lft), 0);
    chk("rst_rht", int'(rht), 0);
    chk("rst_settled", int'(settled), 1);
    chk("rst_ramping", int'(ramping), 0);
    chk("rst_tgt_rdy", int'(tgt_rdy), 1);

    send(20, -20);
    wait_change("t2");
    chk("t2_first_lft", int'(lft), 8);
    chk("t2_first_rht", int'(rht), -8);
    chk("t2_ramping", int'(ramping), 1);
    chk("t2_not_settled", int'(settled), 0);
    wait_settled("t2", 20, -20);
    chk("t2_settled", int'(settled), 1);

    send(0, 0);
    wait_settled("zero_a", 0, 0);

    // Brake mid-ramp; a target offered during the brake must be refused.
    send(500, 100);
    wait_lft("t4", 400);
    chk("t4_ramping", int'(ramping), 1);
    brake = 1'b1;
    @(negedge clk);
    chk("t4_rdy_low", int'(tgt_rdy), 0);
    tgt_lft = 11'sd300;
    tgt_rht = 11'sd300;
    tgt_vld = 1'b1;
    wait_change("t4_brk");
    chk("t4_brake_first", int'(lft), 336);
    n = 0;
    while ((lft != 0 || rht != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_brake_timeout", int'(n < 200), 1);
    repeat (6) @(negedge clk);
    tgt_vld = 1'b0;
    brake   = 1'b0;
    wait_settled("t4", 0, 0);
    chk("t4_settled", int'(settled), 1);

    send(-1024, 0);
    wait_settled("t3", -1023, 0);

    send(0, 0);
    wait_settled("zero_b", 0, 0);

    send(100, 0);
    wait_lft("t5", 16);
    send(-8, 0);
    wait_change("t5");
    chk("t5_next_lft", int'(lft), DECEL_ON ? 0 : 8);
    wait_settled("t5", -8, 0);

    // Asynchronous reset in the middle of a ramp.
    send(400, -400);
    wait_lft("t6", 200);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_lft", int'(lft), 0);
    chk("t6_async_rht", int'(rht), 0);
    chk("t6_async_settled", int'(settled), 1);
    chk("t6_async_ramping", int'(ramping), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5 * TICK_DIV) @(negedge clk);
    chk("t6_hold_lft", int'(lft), 0);
    chk("t6_hold_rht", int'(rht), 0);
    chk("t6_hold_settled", int'(settled), 1);

    for (int i = 0; i < 25; i++) begin
      int l, r, mode, el, er;
      l = int'($urandom_range(600)) - 300;
      r = int'($urandom_range(600)) - 300;
      if ($urandom_range(7) == 0) l = -1024;
      if ($urandom_range(7) == 0) r = 1023;
      send(l, r);
      mode = int'($urandom_range(3));
      el = clampi(l);
      er = clampi(r);
      if (mode == 0) begin
        repeat ($urandom_range(40)) @(negedge clk);
        l = int'($urandom_range(600)) - 300;
        r = -1024;
        send(l, r);
        el = clampi(l);
        er = clampi(r);
      end else if (mode == 1) begin
        repeat ($urandom_range(40)) @(negedge clk);
        brake = 1'b1;
        repeat ($urandom_range(20, 1)) @(negedge clk);
        brake = 1'b0;
        el = 0;
        er = 0;
      end
      wait_settled("rand", el, er);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
